// File: rtl/seq_pkg.sv
// Shared definitions for the sequence monitor.
//   state_t  : monitor FSM states
//   COUNT_W  : width of the upstream count / run length
//   STAT_W   : width of the saturating statistics counters
package seq_pkg;

    localparam int COUNT_W = 4;
    localparam int STAT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_monitor_if.sv
// Sample/status bundle between a sequence source and the monitor.
//   in_valid, in_count, clear           : driven by the source (master)
//   locked, err_pulse, match_pulse,
//   err_count, wrap_count               : driven by the monitor (slave)
interface seq_monitor_if;
    import seq_pkg::*;

    logic               in_valid;
    logic [COUNT_W-1:0] in_count;
    logic               clear;
    logic               locked;
    logic               err_pulse;
    logic               match_pulse;
    logic [STAT_W-1:0]  err_count;
    logic [STAT_W-1:0]  wrap_count;

    modport master (
        output in_valid, in_count, clear,
        input  locked, err_pulse, match_pulse, err_count, wrap_count
    );

    modport slave (
        input  in_valid, in_count, clear,
        output locked, err_pulse, match_pulse, err_count, wrap_count
    );
endinterface

// File: rtl/seq_monitor_sat_counter.sv
// Saturating up-counter used for the monitor statistics.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : count up by one unless already all-ones
//   clr          : synchronous clear, wins over inc
//   count        : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/seq_monitor.sv
// Monitors a free-running 4-bit count stream, locks after LOCK_THRESH
// consecutive in-sequence samples and reports breaks, wraps and TARGET hits.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_count/clear in; locked, err_pulse,
//                  match_pulse, err_count, wrap_count out (all registered)
module seq_monitor
    import seq_pkg::*;
#(
    parameter int                 LOCK_THRESH = 4,
    parameter logic [COUNT_W-1:0] TARGET      = 4'hA
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_monitor_if.slave bus
);

    localparam logic [COUNT_W:0] THRESH = (COUNT_W+1)'(LOCK_THRESH);

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] run_reg, run_next;
    logic [COUNT_W-1:0] last_reg, last_next;
    logic               locked_reg;
    logic               err_pulse_reg, err_pulse_next;
    logic               match_pulse_reg, match_pulse_next;

    // index 0: sequence breaks, index 1: 15->0 wraps while locked
    logic [1:0]         stat_inc;
    logic [STAT_W-1:0]  stat_cnt [2];

    logic               in_seq;
    logic [COUNT_W:0]   run_inc;

    // Natural 4-bit overflow gives the 15 -> 0 continuation for free.
    assign in_seq  = (bus.in_count == (last_reg + {{(COUNT_W-1){1'b0}}, 1'b1}));
    assign run_inc = {1'b0, run_reg} + {{COUNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_next       = state_reg;
        run_next         = run_reg;
        last_next        = last_reg;
        err_pulse_next   = 1'b0;
        match_pulse_next = 1'b0;
        stat_inc         = 2'b00;

        if (bus.clear) begin
            // A sample presented together with clear is dropped.
            state_next = ST_IDLE;
            run_next   = '0;
            last_next  = '0;
        end else if (bus.in_valid) begin
            last_next        = bus.in_count;
            match_pulse_next = (bus.in_count == TARGET);
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ACQUIRE;
                    run_next   = {{(COUNT_W-1){1'b0}}, 1'b1};
                end
                ST_ACQUIRE: begin
                    if (in_seq) begin
                        run_next = run_inc[COUNT_W-1:0];
                        // >= rather than == so a run re-entered at 2 from
                        // ERROR still locks when LOCK_THRESH is 2.
                        if (run_inc >= THRESH) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        run_next = {{(COUNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_LOCKED: begin
                    if (in_seq) begin
                        stat_inc[1] = (last_reg == 4'hF);
                    end else begin
                        state_next     = ST_ERROR;
                        err_pulse_next = 1'b1;
                        stat_inc[0]    = 1'b1;
                    end
                end
                ST_ERROR: begin
                    state_next = ST_ACQUIRE;
                    run_next   = in_seq ? COUNT_W'(2) : COUNT_W'(1);
                end
                default: begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            run_reg         <= '0;
            last_reg        <= '0;
            locked_reg      <= 1'b0;
            err_pulse_reg   <= 1'b0;
            match_pulse_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_reg         <= run_next;
            last_reg        <= last_next;
            locked_reg      <= (state_next == ST_LOCKED);
            err_pulse_reg   <= err_pulse_next;
            match_pulse_reg <= match_pulse_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        sat_counter #(
            .WIDTH (STAT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (stat_inc[gi]),
            .clr     (bus.clear),
            .count   (stat_cnt[gi])
        );
    end

    assign bus.locked      = locked_reg;
    assign bus.err_pulse   = err_pulse_reg;
    assign bus.match_pulse = match_pulse_reg;
    assign bus.err_count   = stat_cnt[0];
    assign bus.wrap_count  = stat_cnt[1];

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: the stimulus process updates a
// behavioural model and queues the outputs expected after the next clock
// edge; a monitor on the falling edge pops and compares them.
module tb_seq_monitor;

    typedef struct {
        bit       locked;
        bit       err;
        bit       match;
        bit [7:0] errc;
        bit [7:0] wrapc;
    } exp_t;

    logic clk;
    logic reset_n;
    seq_monitor_if bus ();

    seq_monitor #(
        .LOCK_THRESH (4),
        .TARGET      (4'hA)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: described in terms of "has the stream started",
    // "are we locked", "did we just break", plus a run length.
    bit m_started, m_locked, m_broken;
    int m_run, m_last, m_errs, m_wraps;

    task automatic model_reset();
        m_started = 0; m_locked = 0; m_broken = 0;
        m_run = 0; m_last = 0; m_errs = 0; m_wraps = 0;
    endtask

    task automatic model_step(input bit v, input int cnt, input bit clr, output exp_t e);
        bit inseq;
        e.err = 0;
        e.match = 0;
        if (clr) begin
            m_started = 0; m_locked = 0; m_broken = 0;
            m_run = 0; m_last = 0; m_errs = 0; m_wraps = 0;
        end else if (v) begin
            inseq   = m_started && (cnt == (m_last + 1) % 16);
            e.match = (cnt == 10);
            if (!m_started) begin
                m_started = 1;
                m_run = 1;
            end else if (m_locked) begin
                if (inseq) begin
                    if (m_last == 15 && m_wraps < 255) m_wraps++;
                end else begin
                    m_locked = 0;
                    m_broken = 1;
                    e.err = 1;
                    if (m_errs < 255) m_errs++;
                end
            end else if (m_broken) begin
                m_broken = 0;
                m_run = inseq ? 2 : 1;
            end else begin
                m_run = inseq ? m_run + 1 : 1;
                if (m_run >= 4) m_locked = 1;
            end
            m_last = cnt;
        end
        e.locked = m_locked;
        e.errc   = 8'(m_errs);
        e.wrapc  = 8'(m_wraps);
    endtask

    // One transaction per cycle, driven just after the falling edge so the
    // monitor has already consumed the previous expectation.
    task automatic drive(input bit v, input int cnt, input bit clr);
        exp_t e;
        @(negedge clk);
        #1;
        bus.in_valid = v;
        bus.in_count = 4'(cnt);
        bus.clear    = clr;
        model_step(v, cnt, clr, e);
        exp_q.push_back(e);
    endtask

    task automatic feed(input int start, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1, (start + i) % 16, 0);
            for (int g = 0; g < gap; g++) drive(0, 0, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.match_pulse !== 1'b0 ||
            bus.err_count !== 8'h00 || bus.wrap_count !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: got locked=%b err=%b match=%b errc=%0d wrapc=%0d, required all zero",
                     tag, bus.locked, bus.err_pulse, bus.match_pulse, bus.err_count, bus.wrap_count);
        end else begin
            $display("check %s: outputs at reset values", tag);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.locked !== e.locked || bus.err_pulse !== e.err || bus.match_pulse !== e.match ||
                bus.err_count !== e.errc || bus.wrap_count !== e.wrapc) begin
                n_bad++;
                $display("FAIL out@cyc%0d: got lk=%b er=%b mt=%b ec=%0d wc=%0d, required lk=%b er=%b mt=%b ec=%0d wc=%0d",
                         cyc, bus.locked, bus.err_pulse, bus.match_pulse, bus.err_count, bus.wrap_count,
                         e.locked, e.err, e.match, e.errc, e.wrapc);
            end else begin
                $display("txn cyc%0d: lk=%b er=%b mt=%b ec=%0d wc=%0d",
                         cyc, bus.locked, bus.err_pulse, bus.match_pulse, bus.err_count, bus.wrap_count);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int drained;
        bus.in_valid = 0;
        bus.in_count = 0;
        bus.clear    = 0;
        reset_n      = 0;
        model_reset();
        #3;
        check_reset_values("power_on_reset");
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1;

        // Lock on 0..3, then break with 5 and relock on 6,7,8.
        feed(0, 4, 0);
        feed(5, 4, 0);
        // Stay locked to 12, then wrap through 15->0 with idle gaps.
        feed(9, 4, 0);
        feed(13, 5, 2);

        // TARGET seen in ACQUIRE (8,9,10) and again while locked.
        drive(0, 0, 1);
        feed(8, 19, 0);

        // Many breaks to saturate err_count.
        drive(0, 0, 1);
        for (int k = 0; k < 300; k++) begin
            s = (m_last + 2 + $urandom_range(0, 13)) % 16;
            feed(s, 4, 0);
        end
        // Clear with a simultaneous sample: the sample must be dropped.
        drive(1, 7, 1);
        feed(8, 5, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive($urandom_range(0, 1), $urandom_range(0, 15), 1);
            end else if ($urandom_range(0, 3) == 0) begin
                drive(0, $urandom_range(0, 15), 0);
            end else if ($urandom_range(0, 4) == 0) begin
                drive(1, $urandom_range(0, 15), 0);
            end else begin
                drive(1, (m_last + 1) % 16, 0);
            end
        end

        // Asynchronous reset in the middle of a lock.
        feed(3, 6, 0);
        drive(0, 0, 0);
        @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        check_reset_values("async_reset_midlock");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset_held");
        reset_n = 1;
        // First sample after reset is an entry sample; 9 is not "in sequence"
        // from the reset value of last, yet the run restarts at 1.
        feed(9, 4, 0);
        feed(15, 3, 1);
        drive(0, 0, 0);

        drained = 0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() == 0) drained = 1;
        n_cmp++;
        if (!drained) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter LOCK_THRESH SHALL default to 4, meaning consecutive in-sequence samples needed to lock (legal range 2..15).
REQ-003 Parameter TARGET SHALL default to 4'hA, meaning the count value that raises match_pulse.
REQ-004 Ports (name, direction, width, meaning) SHALL be exactly:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_count is a sample this cycle
- in_count  input  4  count value from the upstream sequence generator
- clear  input  1  synchronous soft clear
- locked  output  1  monitor is in LOCKED state
- err_pulse  output  1  one-cycle pulse on sequence break while locked
- match_pulse  output  1  one-cycle pulse when an accepted sample equals TARGET
- err_count  output  8  saturating count of sequence breaks
- wrap_count  output  8  saturating count of 15->0 wraps seen while locked

Function
REQ-005 A sample SHALL be accepted only in a cycle where in_valid=1; cycles with in_valid=0 SHALL leave all state unchanged and force the pulse outputs to 0.
REQ-006 A sample SHALL be "in sequence" when in_count == (last accepted value + 1) mod 16; 4'hF followed by 4'h0 is in sequence.
REQ-007 FSM states SHALL be IDLE, ACQUIRE, LOCKED and ERROR; run is a 4-bit count of consecutive in-sequence samples, including the first sample of the run.
REQ-008 IDLE: first accepted sample -> ACQUIRE, run=1, last=sample.
REQ-009 ACQUIRE: in-sequence -> run+1, and go to LOCKED when run+1 == LOCK_THRESH; out-of-sequence -> run=1, stay in ACQUIRE, no error.
REQ-010 LOCKED: in-sequence -> stay; out-of-sequence -> ERROR, err_pulse=1, err_count+1.
REQ-011 ERROR: next accepted sample -> ACQUIRE with run=2 if in sequence, else run=1; ERROR SHALL persist across in_valid=0 cycles.
REQ-012 last SHALL update on every accepted sample, in every state.
REQ-013 wrap_count SHALL increment on an accepted in-sequence sample in LOCKED where last=4'hF and in_count=4'h0.
REQ-014 match_pulse SHALL fire for an accepted sample equal to TARGET, in any state.
REQ-015 err_count and wrap_count SHALL saturate at 8'hFF and never wrap.
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the sampling edge; locked SHALL equal (state==LOCKED).
REQ-017 clear=1 SHALL return the block to IDLE, zero both counters and pulses, and take priority over a simultaneous in_valid=1 (that sample is discarded).

Reset
REQ-018 With reset_n=0, the block SHALL immediately be in state IDLE with run=0, last=0, locked=0, err_pulse=0, match_pulse=0, err_count=0 and wrap_count=0.
REQ-019 Reset asserted mid-operation SHALL abandon any lock or run with no pulse generated; the first sample after deassertion SHALL be treated as an IDLE entry sample.

Structure
REQ-020 Package seq_pkg SHALL hold the FSM state enum, COUNT_W=4 and STAT_W=8.
REQ-021 The two statistics counters SHALL be instances of one sub-module, sat_counter (parameter width, inputs inc and clr, saturating).

Verification
REQ-022 Reset, then valid 0,1,2,3 on consecutive cycles -> locked=1 one cycle after sample 3, with err_count=0.
REQ-023 Locked at 3, then feed 5,6,7,8 -> err_pulse for one cycle after 5, err_count=1, locked=0; relock after 8 (ERROR->run 2 on 6, 3 on 7, 4 on 8).
REQ-024 Locked stream 13,14,15,0,1 with in_valid=0 gap cycles between samples -> lock held, wrap_count=1, no err_pulse.
REQ-025 Stream containing 4'hA in ACQUIRE and again in LOCKED -> match_pulse exactly twice, each for one cycle.
REQ-026 Force 300 breaks (alternate lock and jump) -> err_count holds 8'hFF; then clear=1 together with in_valid=1 -> IDLE, err_count=0, and that sample is ignored.
REQ-027 Pull reset_n low asynchronously mid-LOCKED -> outputs return to reset values without waiting for a clock edge.
